// File: rtl/traffic_pkg.sv
// Shared lamp codes, fault causes and monitor states for the traffic conflict monitor.
package traffic_pkg;

   localparam int unsigned LAMP_W = 3;
   localparam int unsigned FLT_W  = 3;

   typedef logic [LAMP_W-1:0] lamp_t;

   localparam lamp_t LAMP_GRN = 3'b001;
   localparam lamp_t LAMP_YEL = 3'b010;
   localparam lamp_t LAMP_RED = 3'b100;
   localparam lamp_t LAMP_OFF = 3'b000;

   // Four approaches bundled in driver order
   typedef struct packed {
      lamp_t n;
      lamp_t s;
      lamp_t e;
      lamp_t w;
   } lamps_t;

   localparam lamps_t ALL_RED = '{n: LAMP_RED, s: LAMP_RED, e: LAMP_RED, w: LAMP_RED};
   localparam lamps_t ALL_OFF = '{n: LAMP_OFF, s: LAMP_OFF, e: LAMP_OFF, w: LAMP_OFF};

   // Lower value wins when several causes appear in one cycle
   typedef enum logic [FLT_W-1:0] {
      FLT_NONE     = 3'd0,
      FLT_CONFLICT = 3'd1,
      FLT_INVALID  = 3'd2,
      FLT_TRANS    = 3'd3,
      FLT_SHORT_Y  = 3'd4
   } flt_e;

   typedef enum logic [1:0] {
      STARTUP = 2'd0,
      MONITOR = 2'd1,
      FAULT   = 2'd2
   } mon_state_e;

   // True for the three one-hot codes the controller may legally emit
   function automatic logic lamp_valid(input lamp_t c);
      return (c == LAMP_RED) || (c == LAMP_YEL) || (c == LAMP_GRN);
   endfunction

   // Holding a code, or stepping R->G, G->Y, Y->R, is the only legal sequence
   function automatic logic lamp_step_ok(input lamp_t p, input lamp_t c);
      return (p == c) ||
             ((p == LAMP_RED) && (c == LAMP_GRN)) ||
             ((p == LAMP_GRN) && (c == LAMP_YEL)) ||
             ((p == LAMP_YEL) && (c == LAMP_RED));
   endfunction

endpackage

// File: rtl/approach_checker.sv
// Per-approach history tracking and lamp-sequence checks for one traffic approach.
module approach_checker
   import traffic_pkg::*;
#(
   parameter int unsigned MIN_Y = 4
) (
   input  logic  clk,
   input  logic  rst,
   input  lamp_t lamp,
   output logic  invalid_c,
   output logic  illegal_trans_c,
   output logic  short_yellow_c,
   output logic  not_red_c
);

   localparam int unsigned YW = $clog2(MIN_Y + 1);

   lamp_t          prev;
   logic [YW-1:0]  ycnt;

   // Track last lamp code and length of the current yellow, saturating at MIN_Y
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= LAMP_RED;
         ycnt <= YW'(MIN_Y);
      end else begin
         prev <= lamp;
         if (lamp == LAMP_YEL) begin
            if (prev != LAMP_YEL) begin
               ycnt <= YW'(1);
            end else if (ycnt < YW'(MIN_Y)) begin
               ycnt <= ycnt + YW'(1);
            end
         end
      end
   end

   // Raw per-approach flags; the top decides when they matter
   always_comb begin
      invalid_c       = ~lamp_valid(lamp);
      not_red_c       = (lamp != LAMP_RED);
      illegal_trans_c = ~lamp_step_ok(prev, lamp);
      short_yellow_c  = (prev == LAMP_YEL) && (lamp == LAMP_RED) && (ycnt < YW'(MIN_Y));
   end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the traffic light controller and the lamp drivers.
// Passes lamp codes through with one cycle of latency, and on any unsafe
// pattern latches the cause and flashes all approaches red until cleared.
// Optional: define TCM_FAULT_CNT_EN to add an 8-bit saturating fault_cnt output.
module traffic_conflict_monitor
   import traffic_pkg::*;
#(
   parameter int unsigned START_RED = 8,
   parameter int unsigned MIN_Y     = 4,
   parameter int unsigned FLASH_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  n_in,
   input  logic [2:0]  s_in,
   input  logic [2:0]  e_in,
   input  logic [2:0]  w_in,
   input  logic        clr_fault,
   output logic [2:0]  n_out,
   output logic [2:0]  s_out,
   output logic [2:0]  e_out,
   output logic [2:0]  w_out,
   output logic        fault,
   output logic [2:0]  fault_code
`ifdef TCM_FAULT_CNT_EN
   ,
   output logic [7:0]  fault_cnt
`endif
);

   localparam int unsigned SW = $clog2(START_RED + 1);
   localparam int unsigned FW = $clog2(FLASH_DIV + 1);

   mon_state_e     state;
   logic [SW-1:0]  scnt;
   logic [FW-1:0]  fcnt;
   lamps_t         out_q;
   lamps_t         in_bus;

   logic [3:0]     inv;
   logic [3:0]     trans;
   logic [3:0]     shorty;
   logic [3:0]     nred;
   logic [2:0]     nred_cnt;
   logic           conflict_c;
   flt_e           det_c;
   logic           clr_ok_c;

   assign in_bus = {n_in, s_in, e_in, w_in};

   approach_checker #(.MIN_Y(MIN_Y)) u_chk_n (
      .clk(clk), .rst(rst), .lamp(n_in),
      .invalid_c(inv[3]), .illegal_trans_c(trans[3]),
      .short_yellow_c(shorty[3]), .not_red_c(nred[3])
   );

   approach_checker #(.MIN_Y(MIN_Y)) u_chk_s (
      .clk(clk), .rst(rst), .lamp(s_in),
      .invalid_c(inv[2]), .illegal_trans_c(trans[2]),
      .short_yellow_c(shorty[2]), .not_red_c(nred[2])
   );

   approach_checker #(.MIN_Y(MIN_Y)) u_chk_e (
      .clk(clk), .rst(rst), .lamp(e_in),
      .invalid_c(inv[1]), .illegal_trans_c(trans[1]),
      .short_yellow_c(shorty[1]), .not_red_c(nred[1])
   );

   approach_checker #(.MIN_Y(MIN_Y)) u_chk_w (
      .clk(clk), .rst(rst), .lamp(w_in),
      .invalid_c(inv[0]), .illegal_trans_c(trans[0]),
      .short_yellow_c(shorty[0]), .not_red_c(nred[0])
   );

   // Conflict reduction, prioritised fault cause (MONITOR only) and clear qualification
   always_comb begin
      nred_cnt   = 3'($countones(nred));
      conflict_c = (nred_cnt > 3'd1);
      det_c      = FLT_NONE;
      if (state == MONITOR) begin
         if (conflict_c) begin
            det_c = FLT_CONFLICT;
         end else if (|inv) begin
            det_c = FLT_INVALID;
         end else if (|trans) begin
            det_c = FLT_TRANS;
         end else if (|shorty) begin
            det_c = FLT_SHORT_Y;
         end
      end
      clr_ok_c = (state == FAULT) && clr_fault && ~(|inv) && (nred_cnt <= 3'd1);
   end

   // Monitor state machine with registered lamp outputs and fault flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= STARTUP;
         scnt       <= '0;
         fcnt       <= '0;
         out_q      <= ALL_RED;
         fault      <= 1'b0;
         fault_code <= FLT_NONE;
      end else begin
         case (state)
            STARTUP: begin
               if (scnt == SW'(START_RED - 1)) begin
                  state <= MONITOR;
                  out_q <= in_bus;
               end else begin
                  scnt  <= scnt + SW'(1);
                  out_q <= ALL_RED;
               end
            end
            MONITOR: begin
               if (det_c != FLT_NONE) begin
                  state      <= FAULT;
                  fault      <= 1'b1;
                  fault_code <= det_c;
                  fcnt       <= '0;
                  out_q      <= ALL_RED;
               end else begin
                  out_q <= in_bus;
               end
            end
            FAULT: begin
               if (clr_ok_c) begin
                  state      <= STARTUP;
                  fault      <= 1'b0;
                  fault_code <= FLT_NONE;
                  scnt       <= '0;
                  out_q      <= ALL_RED;
               end else if (fcnt == FW'(FLASH_DIV - 1)) begin
                  fcnt  <= '0;
                  out_q <= (out_q.n == LAMP_RED) ? ALL_OFF : ALL_RED;
               end else begin
                  fcnt <= fcnt + FW'(1);
               end
            end
            default: begin
               state <= STARTUP;
               scnt  <= '0;
               out_q <= ALL_RED;
            end
         endcase
      end
   end

   assign n_out = out_q.n;
   assign s_out = out_q.s;
   assign e_out = out_q.e;
   assign w_out = out_q.w;

`ifdef TCM_FAULT_CNT_EN
   // Saturating count of FAULT entries; survives fault clears, reset only by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fault_cnt <= 8'd0;
      end else if ((det_c != FLT_NONE) && (fault_cnt != 8'hFF)) begin
         fault_cnt <= fault_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: doc/traffic_conflict_monitor.md
Name: traffic_conflict_monitor

Overview:
- Sits directly downstream of the four-approach traffic light controller, between its lamp outputs (n, s, e, w) and the physical lamp drivers.
- In normal operation it passes the lamp codes through, registered, with 1-cycle latency.
- It checks every cycle for unsafe or illegal lamp patterns. On any fault it latches the fault and forces all approaches to flashing red until cleared.

Parameters:
- START_RED, 8: cycles of forced all-red after reset or after a fault clear, before pass-through begins.
- MIN_Y, 4: minimum legal yellow duration in cycles.
- FLASH_DIV, 4: cycles per half-period of the fault flash.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- n_in, s_in, e_in, w_in  input  3 each  lamp code from the controller: 001 green, 010 yellow, 100 red.
- clr_fault  input  1  fault clear request, single-cycle pulse or level.
- n_out, s_out, e_out, w_out  output  3 each  lamp code to the drivers.
- fault  output  1  high while in FAULT.
- fault_code  output  3  latched cause: 0 none, 1 conflict, 2 invalid code, 3 illegal transition, 4 short yellow.

Behaviour:
- Reset (asynchronous, active-high) puts the block in the following state:
  - state = STARTUP; startup counter = 0.
  - All outputs = 100.
  - fault = 0; fault_code = 0.
  - Per-approach prev registers = 100.
  - Yellow counters = MIN_Y (saturated).
- Per-approach tracking runs in every state:
  - prev is registered from the input every cycle.
  - The yellow counter clears to 1 on entry to yellow, increments while yellow persists, and saturates at MIN_Y.
- Per-approach checks are evaluated in MONITOR only:
  - invalid: input is not one of 001, 010 or 100.
  - illegal transition: any change other than R->G, G->Y or Y->R.
  - short yellow: a Y->R change while the yellow counter < MIN_Y.
- Global check: conflict means more than one approach has a non-red input in the same cycle.
- Fault priority when several are detected in one cycle: lowest code wins (1 > 2 > 3 > 4).
- STARTUP state:
  - Outputs are forced to 100.
  - The counter counts to START_RED-1, then the block moves to MONITOR.
- MONITOR state:
  - Outputs = inputs from the previous cycle.
  - A fault detected on the inputs at cycle k gives, at edge k+1:
    - state = FAULT, fault = 1, fault_code latched;
    - outputs never show the faulty pattern.
- FAULT state:
  - All four outputs toggle together between 100 and 000 every FLASH_DIV cycles, starting at 100.
  - The flash counter restarts on FAULT entry.
  - fault_code holds until the fault is cleared; further faults are ignored.
- Clearing a fault:
  - clr_fault is honoured only in FAULT, and only when the current inputs are all valid codes with at most one approach non-red.
  - When honoured, the next edge gives state = STARTUP, fault = 0, fault_code = 0, startup counter = 0.
  - A clr_fault that is not honoured is dropped; it is not queued.
- clr_fault has no effect in STARTUP or MONITOR.
- A reset asserted at any point, including mid-flash or mid-startup, returns the block to the reset state immediately.
- Entering MONITOR part-way through a yellow is not flagged, because the yellow counter was already counting during STARTUP (or starts saturated after reset).

Optional Feature:
- Macro: TCM_FAULT_CNT_EN.
- When defined:
  - Adds output port fault_cnt (8 bits): a saturating count of FAULT entries.
  - Reset to 0 by rst only; clr_fault does not clear it.
  - Saturates at 255.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package traffic_pkg holds:
  - lamp code constants LAMP_RED, LAMP_YEL, LAMP_GRN;
  - fault code constants FLT_NONE, FLT_CONFLICT, FLT_INVALID, FLT_TRANS, FLT_SHORT_Y;
  - monitor state encoding STARTUP, MONITOR, FAULT.
- Sub-module approach_checker, instantiated four times:
  - contains the prev register and yellow counter;
  - produces invalid, illegal_trans, short_yellow and not_red flags.
- Top level holds:
  - the conflict reduction;
  - the priority encode;
  - the state machine, flash counter and output muxing.

Test Plan:
- Reset, then drive the legal controller sequence: NG for 8 cycles, NY for 4 cycles, then SG.
  - Outputs are 100 on all approaches for 8 cycles, then mirror the inputs delayed by 1.
  - fault stays 0 through a full N/S/E/W cycle.
- In MONITOR, drive n_in = 001 and e_in = 001 together.
  - Next cycle: fault = 1, fault_code = 1, all outputs 100.
  - Thereafter the outputs alternate 100 / 000 every 4 cycles.
- In MONITOR, drive NY for only 2 cycles, then n_in = 100 → fault_code = 4.
- Separately, n_in 001 -> 100 directly → fault_code = 3.
- Separately, n_in = 011 → fault_code = 2.
- In FAULT:
  - pulse clr_fault while inputs show a conflict → stays in FAULT;
  - make the inputs legal, then pulse clr_fault → fault = 0, fault_code = 0, 8 cycles of all-red, then pass-through resumes.
- Assert rst mid-flash → outputs 100 immediately, fault = 0, STARTUP restarts.
- With TCM_FAULT_CNT_EN defined, cause 3 faults → fault_cnt = 3; clr_fault leaves it at 3; rst sets it to 0.
